inst_encoder: RTL and testbench

//  Inverse of the immediate generator: packs register/funct fields and a 32-bit immediate into RV32I instruction words.

---
 rtl/rv32_pkg.sv | 34 +++
 rtl/inst_pack.sv | 54 +++++
 rtl/inst_encoder.sv | 152 +++++++++++++++
 tb/tb_inst_encoder.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants: immediate formats, major opcodes and encoder FSM states.
package rv32_pkg;

    localparam logic [2:0] FMT_I     = 3'b000;
    localparam logic [2:0] FMT_B     = 3'b001;
    localparam logic [2:0] FMT_J     = 3'b010;
    localparam logic [2:0] FMT_S     = 3'b011;
    localparam logic [2:0] FMT_U     = 3'b100;
    localparam logic [2:0] FMT_L     = 3'b101;
    localparam logic [2:0] FMT_SHIFT = 3'b110;
    localparam logic [2:0] FMT_LI    = 3'b111;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    localparam logic [2:0] F3_ADDI   = 3'b000;

    typedef enum logic {
        S_ACCEPT,
        S_LI_LO
    } enc_state_t;

    // True when v is representable as an nbits-wide two's-complement value.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
        logic [31:0] s;
        s = 32'($signed(v) >>> (nbits - 1));
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I packer: places fields and immediate bits for one format and flags
// immediates that do not fit that format.
module inst_pack
    import rv32_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    always_comb begin
        inst = '0;
        err  = 1'b0;
        case (fmt)
            FMT_I, FMT_L: begin
                inst = {imm[11:0], rs1, funct3, rd, opcode};
                err  = !fits_signed(imm, 12);
            end
            FMT_S: begin
                inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err  = !fits_signed(imm, 12);
            end
            FMT_B: begin
                inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err  = !fits_signed(imm, 13) || imm[0];
            end
            FMT_J: begin
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err  = !fits_signed(imm, 21) || imm[0];
            end
            FMT_U: begin
                inst = {imm[31:12], rd, opcode};
                err  = (imm[11:0] != 12'd0);
            end
            FMT_SHIFT: begin
                inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                err  = (imm[31:5] != 27'd0);
            end
            FMT_LI: begin
                // The top rewrites LI into I/U halves before packing; never an error here.
                inst = {imm[11:0], rs1, funct3, rd, opcode};
                err  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: accepts field/immediate requests, expands LI into LUI+ADDI and
// streams packed words with byte addresses through a single registered output slot.
module inst_encoder
    import rv32_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int                ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    enc_state_t           state_reg, state_next;
    logic [4:0]           li_rd_reg;
    logic [11:0]          li_lo_reg;
    logic                 out_valid_reg;
    logic [31:0]          out_inst_reg;
    logic                 out_err_reg;
    logic [ADDR_W-1:0]    out_addr_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    logic        slot_free, in_fire, load, li_small, is_li, load_err;
    logic [19:0] li_hi;
    logic [2:0]  p_fmt, p_f3;
    logic [6:0]  p_op, p_f7;
    logic [4:0]  p_rd, p_rs1, p_rs2;
    logic [31:0] p_imm, p_inst;
    logic        p_err;

    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = (state_reg == S_ACCEPT) && slot_free;
    assign in_fire   = in_valid && in_ready;
    assign li_small  = fits_signed(in_imm, 12);
    // Round the upper part so the sign-extended ADDI low half lands on the exact value.
    assign li_hi     = in_imm[31:12] + {19'd0, in_imm[11]};
    assign is_li     = (state_reg == S_LI_LO) || (in_fmt == FMT_LI);
    assign load_err  = p_err && !is_li;

    always_comb begin
        p_fmt = in_fmt;
        p_op  = in_opcode;
        p_rd  = in_rd;
        p_rs1 = in_rs1;
        p_rs2 = in_rs2;
        p_f3  = in_funct3;
        p_f7  = in_funct7;
        p_imm = in_imm;
        if (state_reg == S_LI_LO) begin
            p_fmt = FMT_I;
            p_op  = OP_IMM;
            p_rd  = li_rd_reg;
            p_rs1 = li_rd_reg;
            p_f3  = F3_ADDI;
            p_imm = {{20{li_lo_reg[11]}}, li_lo_reg};
        end else if (in_fmt == FMT_LI) begin
            if (li_small) begin
                p_fmt = FMT_I;
                p_op  = OP_IMM;
                p_rs1 = 5'd0;
                p_f3  = F3_ADDI;
            end else begin
                p_fmt = FMT_U;
                p_op  = OP_LUI;
                p_imm = {li_hi, 12'd0};
            end
        end
    end

    inst_pack u_pack (
        .fmt    (p_fmt),
        .opcode (p_op),
        .rd     (p_rd),
        .rs1    (p_rs1),
        .rs2    (p_rs2),
        .funct3 (p_f3),
        .funct7 (p_f7),
        .imm    (p_imm),
        .inst   (p_inst),
        .err    (p_err)
    );

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            S_ACCEPT: begin
                if (in_fire) begin
                    load = 1'b1;
                    if (in_fmt == FMT_LI && !li_small) state_next = S_LI_LO;
                end
            end
            S_LI_LO: begin
                if (slot_free) begin
                    load       = 1'b1;
                    state_next = S_ACCEPT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_ACCEPT;
            li_rd_reg     <= '0;
            li_lo_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_inst_reg  <= '0;
            out_err_reg   <= 1'b0;
            out_addr_reg  <= RESET_ADDR;
            err_cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                out_valid_reg <= 1'b1;
                out_inst_reg  <= p_inst;
                out_err_reg   <= load_err;
                if (load_err && (err_cnt_reg != '1)) err_cnt_reg <= err_cnt_reg + 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (out_valid_reg && out_ready) out_addr_reg <= out_addr_reg + ADDR_W'(4);
            if (in_fire) begin
                li_rd_reg <= in_rd;
                li_lo_reg <= in_imm[11:0];
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_inst  = out_inst_reg;
    assign out_err   = out_err_reg;
    assign out_addr  = out_addr_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed cases plus randomized requests scored
// against an arithmetic reference encoder and an address/error-count model.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    inst_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_addr;
    int          exp_cnt;
    int          checks   = 0;
    int          failures = 0;
    bit          rand_ready = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference encoder: value-range tests and shift/mask arithmetic on the ISA field layout.
    task automatic model_push(input logic [2:0] f, input logic [6:0] op7, input logic [4:0] rd5,
                              input logic [4:0] rs15, input logic [4:0] rs25, input logic [2:0] f33,
                              input logic [6:0] f77, input logic [31:0] imm);
        logic [31:0] o, d, r1, r2, t3, t7, w, hi;
        int s;
        exp_t e;
        o = 32'(op7); d = 32'(rd5); r1 = 32'(rs15); r2 = 32'(rs25); t3 = 32'(f33); t7 = 32'(f77);
        s = imm;
        case (f)
            3'd0, 3'd5: begin
                e.inst = ((imm & 32'hFFF) << 20) | (r1 << 15) | (t3 << 12) | (d << 7) | o;
                e.err  = !(s >= -2048 && s <= 2047);
                exp_q.push_back(e);
            end
            3'd3: begin
                e.inst = (((imm >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (t3 << 12)
                       | ((imm & 32'h1F) << 7) | o;
                e.err  = !(s >= -2048 && s <= 2047);
                exp_q.push_back(e);
            end
            3'd1: begin
                e.inst = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (r2 << 20)
                       | (r1 << 15) | (t3 << 12) | (((imm >> 1) & 32'hF) << 8)
                       | (((imm >> 11) & 1) << 7) | o;
                e.err  = !(s >= -4096 && s <= 4095) || (imm % 2 != 0);
                exp_q.push_back(e);
            end
            3'd2: begin
                e.inst = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                       | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (d << 7) | o;
                e.err  = !(s >= -(1 << 20) && s < (1 << 20)) || (imm % 2 != 0);
                exp_q.push_back(e);
            end
            3'd4: begin
                e.inst = (imm & 32'hFFFFF000) | (d << 7) | o;
                e.err  = (imm % 4096 != 0);
                exp_q.push_back(e);
            end
            3'd6: begin
                e.inst = (t7 << 25) | ((imm & 32'h1F) << 20) | (r1 << 15) | (t3 << 12) | (d << 7) | o;
                e.err  = (imm >= 32);
                exp_q.push_back(e);
            end
            default: begin
                e.err = 1'b0;
                if (s >= -2048 && s <= 2047) begin
                    e.inst = ((imm & 32'hFFF) << 20) | (d << 7) | 32'h13;
                    exp_q.push_back(e);
                end else begin
                    hi = (imm + 32'h800) >> 12;
                    e.inst = (hi << 12) | (d << 7) | 32'h37;
                    exp_q.push_back(e);
                    e.inst = ((imm & 32'hFFF) << 20) | (d << 15) | (d << 7) | 32'h13;
                    exp_q.push_back(e);
                end
            end
        endcase
    endtask

    // Scoreboard: every output handshake is checked against the model, one line per word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", out_inst, 32'hx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.err && exp_cnt != 255) exp_cnt++;
                chk("inst", out_inst, e.inst);
                chk("addr", out_addr, exp_addr);
                chk("err", 32'(out_err), 32'(e.err));
                chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
                $display("word addr=%h inst=%h err=%0d err_cnt=%0d", out_addr, out_inst, out_err, err_cnt);
                exp_addr = exp_addr + 4;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        exp_addr = 0;
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        bit acc = 0;
        int n = 0;
        in_valid = 1'b1; in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        in_valid = 1'b0;
        if (acc) model_push(f, op, rd, rs1, rs2, f3, f7, imm);
        else chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        rand_ready = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_imm();
        logic [11:0] t12;
        logic [12:0] t13;
        logic [20:0] t21;
        case ($urandom_range(0, 6))
            0: return 32'($urandom_range(0, 40));
            1: begin t12 = 12'($urandom); return {{20{t12[11]}}, t12}; end
            2: begin t13 = 13'($urandom); return {{19{t13[12]}}, t13}; end
            3: begin t21 = 21'($urandom); return {{11{t21[20]}}, t21}; end
            4: return $urandom & 32'hFFFFF000;
            5: begin
                case ($urandom_range(0, 3))
                    0: return 32'h0000_07FF;
                    1: return 32'hFFFF_F800;
                    2: return 32'h0000_0800;
                    default: return 32'hFFFF_F7FF;
                endcase
            end
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] a1;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        exp_addr = 0; exp_cnt = 0;
        @(posedge clk); #1;
        do_reset();

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed reference encodings
        send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk);
        chk("i_inst", out_inst, 32'h0050_0093);
        chk("i_addr", out_addr, 32'd0);
        chk("i_err", 32'(out_err), 32'd0);
        @(posedge clk); #1;

        send(3'd1, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("b_inst", out_inst, 32'hFE20_8EE3);
        @(posedge clk); #1;

        send(3'd7, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
        @(negedge clk);
        chk("li_lui", out_inst, 32'h1234_62B7);
        chk("li_lui_addr", out_addr, 32'd8);
        chk("li_lo_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("li_addi", out_inst, 32'hFFF2_8293);
        chk("li_addi_addr", out_addr, 32'd12);
        @(posedge clk); #1;

        send(3'd7, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_07FF);
        @(negedge clk);
        chk("li_small", out_inst, 32'h7FF0_0293);
        @(posedge clk); #1;
        drain();

        // Range error and counter saturation
        do_reset();
        @(negedge clk);
        chk("range_cnt0", 32'(err_cnt), 32'd0);
        @(posedge clk); #1;
        send(3'd0, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        @(negedge clk);
        chk("range_err", 32'(out_err), 32'd1);
        chk("range_cnt1", 32'(err_cnt), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 259; i++)
            send(3'd0, 7'b0010011, 5'(i), 5'd1, 5'd0, 3'd0, 7'd0, 32'h0000_0800 + 32'(i));
        drain();
        @(negedge clk);
        chk("range_sat", 32'(err_cnt), 32'hFF);
        @(posedge clk); #1;

        // Backpressure: first word held, second accepted on the drain cycle
        out_ready = 1'b0;
        send(3'd0, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        a1 = exp_addr;
        in_valid = 1'b1; in_fmt = 3'd3; in_opcode = 7'b0100011; in_rd = 5'd0; in_rs1 = 5'd1;
        in_rs2 = 5'd3; in_funct3 = 3'd2; in_funct7 = 7'd0; in_imm = 32'd8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_inst", out_inst, 32'h0070_0113);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_addr", out_addr, a1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_refill_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_push(3'd3, 7'b0100011, 5'd0, 5'd1, 5'd3, 3'd2, 7'd0, 32'd8);
        @(negedge clk);
        chk("bp_word2", out_inst, 32'h0030_A423);
        chk("bp_addr2", out_addr, a1 + 32'd4);
        @(posedge clk); #1;
        drain();

        // Reset while the ADDI half is pending
        out_ready = 1'b0;
        send(3'd7, 7'd0, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("rli_lui", out_inst, 32'hDEAD_C4B7);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        exp_q.delete();
        exp_addr = 0;
        exp_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rli_addr", out_addr, 32'd0);
        chk("rli_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("rli_no_addi", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;

        // Randomized traffic with random consumer stalls
        rand_ready = 1;
        for (int i = 0; i < 300; i++)
            send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
